// File: rtl/cpu6502_pkg.sv
// Shared encodings for the sequential slice ALU: operation codes, FSM
// states, status-flag bit positions and per-operation flag write enables.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_SBC = 3'b010,
    OP_AND = 3'b011,
    OP_ORA = 3'b100,
    OP_EOR = 3'b101,
    OP_LD  = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  localparam logic [7:0] ENA_ADD   = 8'h00;
  localparam logic [7:0] ENA_ARITH = 8'hC3;
  localparam logic [7:0] ENA_LOGIC = 8'h82;
  localparam logic [7:0] ENA_CMP   = 8'h83;

  // Subtract-type operations feed ~B into the adder.
  function automatic logic is_sub(input op_e op);
    return (op == OP_SBC) || (op == OP_CMP);
  endfunction

  // Carry entering the least-significant slice.
  function automatic logic init_carry(input op_e op, input logic c_in);
    case (op)
      OP_ADC, OP_SBC: return c_in;
      OP_CMP:         return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  // Which flags the surrounding CPU should write back on completion.
  function automatic logic [7:0] flags_ena_for(input op_e op);
    case (op)
      OP_ADD:                         return ENA_ADD;
      OP_ADC, OP_SBC:                 return ENA_ARITH;
      OP_AND, OP_ORA, OP_EOR, OP_LD:  return ENA_LOGIC;
      default:                        return ENA_CMP;
    endcase
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational DATA_W-wide slice: binary add / subtract / logic, with
// optional per-nibble BCD correction when the slice is one byte wide.
module slice_adder
  import cpu6502_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  op_e               op,
  input  logic              bcd,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] res,
  output logic              cout,
  output logic              ovf
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic              bin_ovf;
  logic [DATA_W-1:0] bcd_res;
  logic              bcd_cout;
  logic              bcd_on;

  // Binary sum and signed overflow of this slice.
  always_comb begin
    b_eff   = is_sub(op) ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
    bin_ovf = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  end

  // Decimal correction only exists for byte slices; other widths stay binary.
  if (DATA_W == 8) begin : g_bcd
    logic [4:0] lo;
    logic [4:0] hi;
    logic [3:0] lo_n;
    logic [3:0] hi_n;
    logic       lc;
    logic       hc;

    // Per-nibble decimal adjust; subtraction detects borrow as no carry-out.
    always_comb begin
      lo = {1'b0, a[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, cin};
      if (is_sub(op)) begin
        lc   = lo[4];
        lo_n = lc ? lo[3:0] : lo[3:0] - 4'd6;
      end else begin
        lc   = (lo > 5'd9);
        lo_n = lc ? lo[3:0] + 4'd6 : lo[3:0];
      end
      hi = {1'b0, a[7:4]} + {1'b0, b_eff[7:4]} + {4'b0, lc};
      if (is_sub(op)) begin
        hc   = hi[4];
        hi_n = hc ? hi[3:0] : hi[3:0] - 4'd6;
      end else begin
        hc   = (hi > 5'd9);
        hi_n = hc ? hi[3:0] + 4'd6 : hi[3:0];
      end
      bcd_res  = {hi_n, lo_n};
      bcd_cout = hc;
    end
    assign bcd_on = bcd;
  end else begin : g_no_bcd
    logic unused_bcd;
    assign unused_bcd = bcd;
    assign bcd_res    = '0;
    assign bcd_cout   = 1'b0;
    assign bcd_on     = 1'b0;
  end

  // Select the slice result for the requested operation.
  always_comb begin
    res  = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SBC, OP_CMP: begin
        res  = sum[DATA_W-1:0];
        cout = sum[DATA_W];
        ovf  = bin_ovf;
        if (bcd_on && (op == OP_ADC || op == OP_SBC)) begin
          res  = bcd_res;
          cout = bcd_cout;
        end
      end
      OP_AND:  res = a & b;
      OP_ORA:  res = a | b;
      OP_EOR:  res = a ^ b;
      default: res = b;
    endcase
  end

endmodule

// File: rtl/arith_seq_unit.sv
// Sequential ALU: processes a W = DATA_W*NSLICE operand one slice per cycle,
// least-significant first, chaining carry through a register.
module arith_seq_unit
  import cpu6502_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NSLICE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic                     decimal,
  input  logic [DATA_W*NSLICE-1:0] alu_a,
  input  logic [DATA_W*NSLICE-1:0] alu_b,
  input  logic [7:0]               flags_in,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W*NSLICE-1:0] alu_out,
  output logic [7:0]               flags_out,
  output logic [7:0]               flags_ena
);

  localparam int unsigned W     = DATA_W * NSLICE;
  localparam int unsigned CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              carry;
  op_e               op_q;
  logic              dec_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      res_acc;

  logic [DATA_W-1:0] a_sl;
  logic [DATA_W-1:0] b_sl;
  logic [DATA_W-1:0] s_res;
  logic              s_cout;
  logic              s_ovf;
  logic              bcd_en;
  logic              last;
  logic [W-1:0]      full_res;
  logic [7:0]        next_flags;

  logic unused_flags;
  assign unused_flags = ^flags_in[7:1];

  // Pick the operand slice addressed by the slice counter.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_sl = a_q[i*DATA_W +: DATA_W];
        b_sl = b_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bcd_en = dec_q && (op_q == OP_ADC || op_q == OP_SBC);
  assign last   = (cnt == CNT_W'(NSLICE - 1));

  slice_adder #(.DATA_W(DATA_W)) u_slice (
    .op   (op_q),
    .bcd  (bcd_en),
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry),
    .res  (s_res),
    .cout (s_cout),
    .ovf  (s_ovf)
  );

  // Full result with the current slice merged in, so flags on the final
  // slice see the complete word in the same cycle.
  always_comb begin
    full_res = res_acc;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (cnt == CNT_W'(i)) begin
        full_res[i*DATA_W +: DATA_W] = s_res;
      end
    end
  end

  // Status flags from the final word; V comes from the top slice.
  always_comb begin
    next_flags         = '0;
    next_flags[FLAG_N] = full_res[W-1];
    next_flags[FLAG_V] = s_ovf;
    next_flags[FLAG_Z] = (full_res == '0);
    next_flags[FLAG_C] = s_cout;
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      op_q      <= OP_ADD;
      dec_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_acc   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_out   <= '0;
      flags_out <= '0;
      flags_ena <= '0;
    end else begin
      done      <= 1'b0;
      flags_out <= '0;
      flags_ena <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            dec_q   <= decimal;
            a_q     <= alu_a;
            b_q     <= alu_b;
            carry   <= init_carry(op_e'(op), flags_in[FLAG_C]);
            cnt     <= '0;
            res_acc <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          carry   <= s_cout;
          res_acc <= full_res;
          if (last) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cnt       <= '0;
            flags_out <= next_flags;
            flags_ena <= flags_ena_for(op_q);
            if (op_q != OP_CMP) begin
              alu_out <= full_res;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
